// File: rtl/pcseq_pkg.sv
// rtl/pcseq_pkg.sv - shared state encoding and PC constants for pc_sequencer
package pcseq_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        REDIRECT = 2'd2,
        HALTED   = 2'd3
    } pcseq_state_e;

    localparam int unsigned PC_RESET = 0;
    localparam int unsigned PC_INC   = 4;

    // Fetch targets are word addresses; the low two bits are discarded.
    function automatic logic [31:0] align_target(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pcseq_stats.sv
// rtl/pcseq_stats.sv - saturating redirect and stall counters for pc_sequencer
module pcseq_stats #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             redirect_i,
    input  logic             stall_i,
    output logic [CNT_W-1:0] redirect_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    logic [CNT_W-1:0] redirect_cnt_q, redirect_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Counters stick at all-ones rather than wrapping.
    always_comb begin
        redirect_cnt_d = redirect_cnt_q;
        stall_cnt_d    = stall_cnt_q;
        if (redirect_i && (redirect_cnt_q != '1)) begin
            redirect_cnt_d = redirect_cnt_q + 1'b1;
        end
        if (stall_i && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            redirect_cnt_q <= '0;
            stall_cnt_q    <= '0;
        end else begin
            redirect_cnt_q <= redirect_cnt_d;
            stall_cnt_q    <= stall_cnt_d;
        end
    end

    assign redirect_cnt_o = redirect_cnt_q;
    assign stall_cnt_o    = stall_cnt_q;

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch PC sequencer FSM; PCSEQ_STATS_EN enables statistics counters
module pc_sequencer
    import pcseq_pkg::*;
#(
    parameter int PC_W  = 9,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             FetchAck,
    input  logic             Stall,
    input  logic             PcSel,
    input  logic [31:0]      BrPC,
    input  logic             Halt,
    output logic [PC_W-1:0]  PC,
    output logic             FetchReq,
    output logic             FlushIFID,
    output logic             FlushIDEX,
    output logic             Halted,
    output logic             MisalignErr,
    output logic [CNT_W-1:0] RedirectCnt,
    output logic [CNT_W-1:0] StallCnt
);

    pcseq_state_e    state_q;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pend_q;
    logic            misalign_q;
    logic            fetch_req_q;
    logic            halted_q;

    logic [31:0]     target_full;
    logic [PC_W-1:0] target;
    logic [PC_W-1:0] pc_inc;
    logic            target_odd;
    logic            flush_idex;
    logic            unused_brpc_hi;

    assign target_full    = align_target(BrPC);
    assign target         = target_full[PC_W-1:0];
    assign target_odd     = (BrPC[1:0] != 2'b00);
    assign pc_inc         = pc_q + PC_W'(PC_INC);
    assign unused_brpc_hi = ^target_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            pc_q        <= PC_W'(PC_RESET);
            pend_q      <= '0;
            misalign_q  <= 1'b0;
            fetch_req_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q     <= RUN;
                    fetch_req_q <= 1'b1;
                end
                RUN: begin
                    if (Halt) begin
                        state_q     <= HALTED;
                        fetch_req_q <= 1'b0;
                        halted_q    <= 1'b1;
                    end else if (PcSel) begin
                        if (target_odd) misalign_q <= 1'b1;
                        if (FetchAck) begin
                            pc_q <= target;
                        end else begin
                            pend_q  <= target;
                            state_q <= REDIRECT;
                        end
                    end else if (!Stall && FetchAck) begin
                        pc_q <= pc_inc;
                    end
                end
                REDIRECT: begin
                    // Stall is deliberately ignored here; the fetch of the target must complete.
                    if (Halt) begin
                        state_q     <= HALTED;
                        fetch_req_q <= 1'b0;
                        halted_q    <= 1'b1;
                        pend_q      <= '0;
                    end else if (PcSel) begin
                        if (target_odd) misalign_q <= 1'b1;
                        if (FetchAck) begin
                            pc_q    <= target;
                            state_q <= RUN;
                        end else begin
                            pend_q <= target;
                        end
                    end else if (FetchAck) begin
                        pc_q    <= pend_q;
                        state_q <= RUN;
                    end
                end
                HALTED: begin
                    state_q <= HALTED;
                end
                default: begin
                    state_q     <= IDLE;
                    fetch_req_q <= 1'b0;
                    halted_q    <= 1'b0;
                end
            endcase
        end
    end

    // Outputs are forced quiet while reset is held, even before the first reset edge.
    assign flush_idex  = !reset && (state_q == RUN) && PcSel && !Halt;
    assign FlushIDEX   = flush_idex;
    assign FlushIFID   = flush_idex || (!reset && (state_q == REDIRECT));
    assign FetchReq    = fetch_req_q && !reset;
    assign Halted      = halted_q && !reset;
    assign PC          = pc_q;
    assign MisalignErr = misalign_q;

`ifdef PCSEQ_STATS_EN
    logic stall_hold;

    assign stall_hold = !reset && (state_q == RUN) && !Halt && !PcSel && Stall;

    pcseq_stats #(
        .CNT_W (CNT_W)
    ) u_stats (
        .clk            (clk),
        .reset          (reset),
        .redirect_i     (flush_idex),
        .stall_i        (stall_hold),
        .redirect_cnt_o (RedirectCnt),
        .stall_cnt_o    (StallCnt)
    );
`else
    assign RedirectCnt = '0;
    assign StallCnt    = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer with directed vectors
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        FetchAck;
    logic        Stall;
    logic        PcSel;
    logic [31:0] BrPC;
    logic        Halt;
    logic [8:0]  PC;
    logic        FetchReq;
    logic        FlushIFID;
    logic        FlushIDEX;
    logic        Halted;
    logic        MisalignErr;
    logic [15:0] RedirectCnt;
    logic [15:0] StallCnt;

    pc_sequencer #(.PC_W(9), .CNT_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .FetchAck    (FetchAck),
        .Stall       (Stall),
        .PcSel       (PcSel),
        .BrPC        (BrPC),
        .Halt        (Halt),
        .PC          (PC),
        .FetchReq    (FetchReq),
        .FlushIFID   (FlushIFID),
        .FlushIDEX   (FlushIDEX),
        .Halted      (Halted),
        .MisalignErr (MisalignErr),
        .RedirectCnt (RedirectCnt),
        .StallCnt    (StallCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [8:0]  pc;
        logic        freq;
        logic        fifid;
        logic        fidex;
        logic        halted;
        logic        mis;
        bit          chk_cnt;
        logic [15:0] rcnt;
        logic [15:0] scnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    bit          cnt_next = 0;
    logic [15:0] rcnt_next = '0;
    logic [15:0] scnt_next = '0;

`ifdef PCSEQ_STATS_EN
    localparam logic [15:0] RCNT_FINAL = 16'd5;
    localparam logic [15:0] SCNT_FINAL = 16'd2;
`else
    localparam logic [15:0] RCNT_FINAL = 16'd0;
    localparam logic [15:0] SCNT_FINAL = 16'd0;
`endif

    task automatic chk(input string n, input string f, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %h expected %h", n, f, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk(e.name, "PC",          32'(PC),          32'(e.pc));
            chk(e.name, "FetchReq",    32'(FetchReq),    32'(e.freq));
            chk(e.name, "FlushIFID",   32'(FlushIFID),   32'(e.fifid));
            chk(e.name, "FlushIDEX",   32'(FlushIDEX),   32'(e.fidex));
            chk(e.name, "Halted",      32'(Halted),      32'(e.halted));
            chk(e.name, "MisalignErr", 32'(MisalignErr), 32'(e.mis));
            if (e.chk_cnt) begin
                chk(e.name, "RedirectCnt", 32'(RedirectCnt), 32'(e.rcnt));
                chk(e.name, "StallCnt",    32'(StallCnt),    32'(e.scnt));
            end
        end
    end

    task automatic step(input string name, input bit rst, input bit ack, input bit stl,
                        input bit sel, input logic [31:0] br, input bit hlt,
                        input logic [8:0] epc, input bit efreq, input bit eifid,
                        input bit eidex, input bit ehalt, input bit emis);
        exp_t e;
        @(posedge clk);
        #1;
        reset    = rst;
        FetchAck = ack;
        Stall    = stl;
        PcSel    = sel;
        BrPC     = br;
        Halt     = hlt;
        e.name   = name;
        e.pc     = epc;
        e.freq   = efreq;
        e.fifid  = eifid;
        e.fidex  = eidex;
        e.halted = ehalt;
        e.mis    = emis;
        e.chk_cnt = cnt_next;
        e.rcnt   = rcnt_next;
        e.scnt   = scnt_next;
        cnt_next = 0;
        exp_q.push_back(e);
    endtask

    initial begin
        reset    = 1'b1;
        FetchAck = 1'b0;
        Stall    = 1'b0;
        PcSel    = 1'b0;
        BrPC     = '0;
        Halt     = 1'b0;
        repeat (2) @(posedge clk);

        //     name          rst ack stl sel br        hlt  pc     freq ifid idex hlt mis
        step("reset",        1, 0, 0, 0, 32'h0,    0, 9'h000, 0, 0, 0, 0, 0);
        step("idle",         0, 1, 0, 0, 32'h0,    0, 9'h000, 0, 0, 0, 0, 0);
        step("run0",         0, 1, 0, 0, 32'h0,    0, 9'h000, 1, 0, 0, 0, 0);
        step("run4",         0, 1, 0, 0, 32'h0,    0, 9'h004, 1, 0, 0, 0, 0);
        step("run8",         0, 1, 0, 0, 32'h0,    0, 9'h008, 1, 0, 0, 0, 0);
        step("runc",         0, 1, 0, 0, 32'h0,    0, 9'h00C, 1, 0, 0, 0, 0);
        step("br_ack",       0, 1, 0, 1, 32'h40,   0, 9'h010, 1, 1, 1, 0, 0);
        step("at40",         0, 1, 0, 0, 32'h0,    0, 9'h040, 1, 0, 0, 0, 0);
        step("noack_hold",   0, 0, 0, 0, 32'h0,    0, 9'h044, 1, 0, 0, 0, 0);
        step("br_noack",     0, 0, 0, 1, 32'h80,   0, 9'h044, 1, 1, 1, 0, 0);
        step("redir1",       0, 0, 1, 0, 32'h0,    0, 9'h044, 1, 1, 0, 0, 0);
        step("redir2",       0, 0, 0, 0, 32'h0,    0, 9'h044, 1, 1, 0, 0, 0);
        step("redir_ack",    0, 1, 0, 0, 32'h0,    0, 9'h044, 1, 1, 0, 0, 0);
        step("br_to20",      0, 1, 0, 1, 32'h20,   0, 9'h080, 1, 1, 1, 0, 0);
        step("stall1",       0, 1, 1, 0, 32'h0,    0, 9'h020, 1, 0, 0, 0, 0);
        step("stall2",       0, 1, 1, 0, 32'h0,    0, 9'h020, 1, 0, 0, 0, 0);
        step("stall_sel",    0, 1, 1, 1, 32'h30,   0, 9'h020, 1, 1, 1, 0, 0);
        step("sel_pend",     0, 0, 0, 1, 32'h100,  0, 9'h030, 1, 1, 1, 0, 0);
        step("redir_over",   0, 0, 0, 1, 32'h1FE,  0, 9'h030, 1, 1, 0, 0, 0);
        step("redir_mis",    0, 1, 0, 0, 32'h0,    0, 9'h030, 1, 1, 0, 0, 1);
        step("pc_1fc",       0, 1, 0, 0, 32'h0,    0, 9'h1FC, 1, 0, 0, 0, 1);
        step("wrap",         0, 1, 0, 0, 32'h0,    0, 9'h000, 1, 0, 0, 0, 1);
        step("halt_sel",     0, 1, 0, 1, 32'h50,   1, 9'h004, 1, 0, 0, 0, 1);
        step("halted1",      0, 1, 0, 1, 32'h50,   0, 9'h004, 0, 0, 0, 1, 1);
        cnt_next = 1; rcnt_next = RCNT_FINAL; scnt_next = SCNT_FINAL;
        step("halted2",      0, 1, 0, 0, 32'h0,    0, 9'h004, 0, 0, 0, 1, 1);
        step("reset2",       1, 1, 0, 0, 32'h0,    0, 9'h004, 0, 0, 0, 0, 1);
        cnt_next = 1; rcnt_next = 16'd0; scnt_next = 16'd0;
        step("idle2",        0, 0, 0, 0, 32'h0,    0, 9'h000, 0, 0, 0, 0, 0);
        step("run_again",    0, 0, 0, 0, 32'h0,    0, 9'h000, 1, 0, 0, 0, 0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 9, giving the PC width in bits.
REQ-002 SHALL have parameter CNT_W, default 16, giving the statistics counter width.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous reset, active-high.
REQ-005 SHALL have port FetchAck  in  1  imem has returned the instruction at PC this cycle.
REQ-006 SHALL have port Stall  in  1  load-use stall request from the hazard unit.
REQ-007 SHALL have port PcSel  in  1  EX-stage branch taken or redirect.
REQ-008 SHALL have port BrPC  in  32  EX-stage redirect target.
REQ-009 SHALL have port Halt  in  1  halt request.
REQ-010 SHALL have port PC  out  PC_W  registered fetch address.
REQ-011 SHALL have port FetchReq  out  1  fetch of PC requested.
REQ-012 SHALL have port FlushIFID  out  1  bubble the IF/ID register.
REQ-013 SHALL have port FlushIDEX  out  1  bubble the ID/EX register.
REQ-014 SHALL have port Halted  out  1  high while the core is halted.
REQ-015 SHALL have port MisalignErr  out  1  sticky flag: a target had BrPC[1:0] != 0.
REQ-016 SHALL have ports RedirectCnt and StallCnt  out  CNT_W  statistics counters.

Function
REQ-017 SHALL use FSM states IDLE, RUN, REDIRECT and HALTED.
REQ-018 IDLE SHALL last exactly one cycle with FetchReq=0, then go to RUN.
REQ-019 SHALL drive FetchReq=1 in RUN and REDIRECT, and 0 in IDLE and HALTED.
REQ-020 SHALL apply per-cycle priority in RUN as Halt > PcSel > Stall > FetchAck.
REQ-021 RUN with Halt=1 SHALL go to HALTED, freeze PC, and drive both flushes 0 that cycle.
REQ-022 RUN with PcSel=1 and FetchAck=1 SHALL load PC <= target at the next edge and stay in RUN (1-cycle redirect latency).
REQ-023 RUN with PcSel=1 and FetchAck=0 SHALL latch target into a pending register and go to REDIRECT.
REQ-024 The target SHALL be BrPC[PC_W-1:0] with bits [1:0] forced to 0; upper BrPC bits are ignored.
REQ-025 RUN with no PcSel, Stall=1 SHALL hold PC.
REQ-026 RUN otherwise SHALL load PC <= PC+4 when FetchAck=1 and hold PC when FetchAck=0.
REQ-027 PC+4 SHALL wrap modulo 2^PC_W (for PC_W=9, 0x1FC -> 0x000).
REQ-028 FlushIDEX SHALL equal (state==RUN & PcSel & !Halt), combinational.
REQ-029 FlushIFID SHALL equal FlushIDEX | (state==REDIRECT), combinational.
REQ-030 REDIRECT SHALL hold PC, ignore Stall, and on FetchAck=1 load PC <= pending and return to RUN.
REQ-031 A PcSel in REDIRECT SHALL overwrite pending (latest target wins).
REQ-032 Halt in REDIRECT SHALL go to HALTED and discard pending.
REQ-033 HALTED SHALL be left only by reset, with PC frozen; Halted SHALL be registered and equal state==HALTED.
REQ-034 MisalignErr SHALL set on any accepted target with BrPC[1:0] != 0 and clear only on reset.

Reset
REQ-035 Reset SHALL set state=IDLE, PC=0, pending=0, MisalignErr=0 and counters=0.
REQ-036 Reset SHALL take priority over all inputs, including mid-REDIRECT and in HALTED.
REQ-037 While in reset, outputs SHALL be FetchReq=0, flushes=0 and Halted=0.

Configuration
REQ-038 With macro PCSEQ_STATS_EN defined, RedirectCnt SHALL count cycles with FlushIDEX=1.
REQ-039 With PCSEQ_STATS_EN defined, StallCnt SHALL count RUN cycles where Stall held the PC.
REQ-040 Both counters SHALL saturate at all-ones.
REQ-041 Without PCSEQ_STATS_EN, both counter ports SHALL exist and be tied 0, with no counter flops.

Structure
REQ-042 Package pcseq_pkg SHALL hold the state enum typedef, PC_RESET=0 and the PC increment constant 4.
REQ-043 Counters SHALL live in sub-module pcseq_stats, instantiated only under PCSEQ_STATS_EN.

Verification
REQ-044 Reset then FetchAck=1 constant -> IDLE one cycle with FetchReq=0; PC sequence 0,0,4,8,...
REQ-045 PC=0x010, PcSel=1, BrPC=0x40, FetchAck=1 -> FlushIFID=FlushIDEX=1 that cycle; PC=0x040 next cycle.
REQ-046 PcSel=1, BrPC=0x80, FetchAck=0 for 3 cycles -> REDIRECT with FlushIFID=1 and FlushIDEX=0; PC=0x080 after FetchAck.
REQ-047 Stall=1 for 2 cycles at PC=0x020 -> PC held; Stall and PcSel together -> redirect wins; StallCnt=2 with macro defined.
REQ-048 Halt=1 with PcSel=1 -> no flush, Halted=1 next cycle, PC frozen; only reset restores IDLE.
REQ-049 BrPC=0x1FE -> PC=0x1FC and MisalignErr=1; then PC+4 wraps to 0x000.
